ieee2fp_stream: RTL and testbench
=================================

Name: ieee2fp_stream

Overview:
- Streaming, pipelined IEEE 754 to FloPoCo floating-point converter with valid/ready handshake.
- Generalises the combinational single-shot converter: adds half, single and double precision, configurable register depth, backpressure, tag passthrough and saturating event counters.
- Conversion is native RTL; no vendor core is instantiated.
- Sits in front of FloPoCo arithmetic pipelines that consume streamed operands.

Parameters:
- DataWidth, 32, IEEE width; legal values 16, 32, 64; any other value raises an elaboration $error.
- NumStages, 2, number of elastic register stages; 0 gives a combinational path.
- TagWidth, 1, width of the sideband tag carried alongside the data.
- CntWidth, 16, width of each status counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ieee_i  in  DataWidth  IEEE operand
- tag_i  in  TagWidth  sideband tag
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- fp_o  out  DataWidth+2  FloPoCo result as {exc[1:0], sign, exp, frac}
- tag_o  out  TagWidth  tag belonging to fp_o
- valid_o  out  1  output valid
- ready_i  in  1  output ready
- clr_i  in  1  synchronous clear of both counters
- sub_cnt_o  out  CntWidth  number of subnormals flushed to zero
- nan_cnt_o  out  CntWidth  number of NaNs converted

Behaviour:
- Field widths (E/F): 16 gives 5/10; 32 gives 8/23; 64 gives 11/52.
- Conversion is combinational at the input. Sign is always copied. Cases:
  - exp==0, frac==0: exc=00; exp and frac forced to 0.
  - exp==0, frac!=0 (subnormal): exc=00; exp and frac forced to 0 (flush to signed zero); counts as a subnormal event.
  - exp all ones, frac==0: exc=10; fields copied verbatim.
  - exp all ones, frac!=0: exc=11; fields copied verbatim; counts as a NaN event.
  - otherwise: exc=01; fields copied verbatim.
- Pipeline:
  - NumStages elastic stages, each holding {fp, tag, valid}.
  - Stage k accepts when it is empty or the downstream stage accepts: ready_k = !valid_q[k] || ready_{k+1}.
  - The last stage's downstream is ready_i.
  - ready_o equals the first stage's ready.
- Throughput: 1 item/cycle. Latency with no backpressure: exactly NumStages cycles from input handshake to valid_o.
- Capacity: NumStages items. Under backpressure, items are never dropped, duplicated or reordered.
- Once valid_o is asserted, fp_o and tag_o stay stable until the handshake completes.
- NumStages==0: fp_o = conversion(ieee_i), tag_o = tag_i, valid_o = valid_i, ready_o = ready_i.
- Counters:
  - Increment only on an input handshake (valid_i && ready_o) whose operand triggers that counter's event.
  - Saturate at 2^CntWidth-1; no wrap.
  - clr_i zeroes both counters next cycle. clr_i has priority: an event in the same cycle is not counted.
- Reset values: every stage valid=0, valid_o=0, both counters 0. Stage data registers are don't-care, but fp_o and tag_o read 0 after reset.
- Reset mid-operation: all in-flight items are discarded and counters return to 0. No output is produced for items accepted before reset.
- ready_o after reset: 1 when NumStages>0; follows ready_i when NumStages==0.

Decomposition:
- Package fpnew_flopoco_pkg holds:
  - exc encodings EXC_ZERO=2'b00, EXC_NORMAL=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11;
  - functions exp_bits(DataWidth) and frac_bits(DataWidth);
  - a conversion function ieee2fp_f.
- One sub-module, flopoco_pipe_reg: a single elastic stage with a parametrised data type, instantiated NumStages times in a generate loop.
- Counters are inline.

Test Plan:
- DataWidth=32, NumStages=2, ready_i=1. Stream 0x3F800000, 0x80000000, 0x7F800000, 0x7FC00000 back-to-back. Required: fp_o = 0x13F800000, 0x080000000, 0x27F800000, 0x37FC00000 in order, each 2 cycles after acceptance; nan_cnt_o=1.
- Subnormal inputs 0x00000001 then 0x80400000. Required: fp_o = 0x000000000 and 0x080000000; sub_cnt_o=2.
- DataWidth=16, input 0x3C00. Required: fp_o = 18'h13C00. DataWidth=64, input 0x3FF0000000000000. Required: fp_o = {2'b01, 0x3FF0000000000000}.
- NumStages=3. Stream 8 tagged items (tags 0..7); hold ready_i=0 for cycles 2..6. Required:
  - ready_o drops once 3 items are held;
  - all 8 items emerge in tag order with no loss or duplication;
  - fp_o and tag_o stay stable while valid_o && !ready_i.
- CntWidth=2. Feed 5 NaNs, then NaN together with clr_i=1. Required: nan_cnt_o saturates at 3 and reads 0 after the clear.
- Assert rst_ni low with 2 items in flight. Required: valid_o=0 and counters=0 immediately (asynchronous reset); no stale item appears after release.

Source files
------------

// File: rtl/ieee2fp_stream_pkg.sv
// Shared definitions for the IEEE 754 -> FloPoCo stream converter.
// Holds the FloPoCo exception encodings, the field-width helpers and the
// combinational conversion function used at the converter input.
package fpnew_flopoco_pkg;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

   // Conversion result sized for the widest format; callers slice it.
   typedef struct packed {
      logic [65:0] fp;
      logic        sub;
      logic        nan;
   } conv_t;

   function automatic int unsigned exp_bits(input int unsigned data_width);
      case (data_width)
         16:      return 5;
         64:      return 11;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned frac_bits(input int unsigned data_width);
      return data_width - 1 - exp_bits(data_width);
   endfunction

   // ieee holds the operand right-aligned; fp is {exc, sign, exp, frac}
   // right-aligned in the same way (data_width+2 significant bits).
   function automatic conv_t ieee2fp_f(input logic [63:0] ieee,
                                       input int unsigned data_width);
      conv_t       res;
      logic        sign;
      logic [10:0] exp_f;
      logic [51:0] frac_f;
      logic        exp_ones;
      logic [1:0]  exc;
      sign     = 1'b0;
      exp_f    = '0;
      frac_f   = '0;
      exp_ones = 1'b0;
      case (data_width)
         16: begin
            sign        = ieee[15];
            exp_f[4:0]  = ieee[14:10];
            frac_f[9:0] = ieee[9:0];
            exp_ones    = &ieee[14:10];
         end
         64: begin
            sign     = ieee[63];
            exp_f    = ieee[62:52];
            frac_f   = ieee[51:0];
            exp_ones = &ieee[62:52];
         end
         default: begin
            sign         = ieee[31];
            exp_f[7:0]   = ieee[30:23];
            frac_f[22:0] = ieee[22:0];
            exp_ones     = &ieee[30:23];
         end
      endcase
      res     = '0;
      res.sub = (exp_f == '0) && (frac_f != '0);
      res.nan = exp_ones && (frac_f != '0);
      if (exp_f == '0) begin
         // zeros and subnormals both leave as a signed zero
         exc    = EXC_ZERO;
         frac_f = '0;
      end else if (exp_ones) begin
         exc = (frac_f == '0) ? EXC_INF : EXC_NAN;
      end else begin
         exc = EXC_NORMAL;
      end
      res.fp = (66'(exc) << data_width)
             | (66'(sign) << (data_width - 1))
             | (66'(exp_f) << frac_bits(data_width))
             | 66'(frac_f);
      return res;
   endfunction

endpackage

// File: rtl/ieee2fp_stream_if.sv
// Stream bundle of the converter: IEEE operand side (ieee_i/tag_i/valid_i
// with ready_o back) and FloPoCo result side (fp_o/tag_o/valid_o with
// ready_i back). slave = converter, master = producer/consumer.
interface ieee2fp_stream_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned TagWidth  = 1
);
   logic [DataWidth-1:0] ieee_i;
   logic [TagWidth-1:0]  tag_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [DataWidth+1:0] fp_o;
   logic [TagWidth-1:0]  tag_o;
   logic                 valid_o;
   logic                 ready_i;

   modport master (
      output ieee_i, tag_i, valid_i, ready_i,
      input  ready_o, fp_o, tag_o, valid_o
   );

   modport slave (
      input  ieee_i, tag_i, valid_i, ready_i,
      output ready_o, fp_o, tag_o, valid_o
   );
endinterface

// File: rtl/ieee2fp_stream_pipe_reg.sv
// flopoco_pipe_reg: one elastic register stage carrying data_t plus valid.
// Ports: clk_i/rst_ni; upstream data_i/valid_i/ready_o;
// downstream data_o/valid_o/ready_i. ready_o = empty || downstream ready.
module flopoco_pipe_reg #(
   parameter type data_t = logic
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  data_t data_i,
   input  logic  valid_i,
   output logic  ready_o,
   output data_t data_o,
   output logic  valid_o,
   input  logic  ready_i
);

   assign ready_o = !valid_o || ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (ready_o) begin
         valid_o <= valid_i;
         if (valid_i) data_o <= data_i;
      end
   end

endmodule

// File: rtl/ieee2fp_stream.sv
// ieee2fp_stream: streaming IEEE 754 (16/32/64) -> FloPoCo converter.
// Ports: clk_i, rst_ni (async, active low); stream (slave bundle: IEEE in,
// FloPoCo out, valid/ready both ways, tag sideband); clr_i clears the
// counters; sub_cnt_o / nan_cnt_o count accepted subnormals / NaNs,
// saturating. Conversion happens at the input, followed by NumStages
// elastic stages (0 = pure combinational pass-through).
module ieee2fp_stream
   import fpnew_flopoco_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumStages = 2,
   parameter int unsigned TagWidth  = 1,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   ieee2fp_stream_if.slave     stream,
   input  logic                clr_i,
   output logic [CntWidth-1:0] sub_cnt_o,
   output logic [CntWidth-1:0] nan_cnt_o
);

   if (DataWidth != 16 && DataWidth != 32 && DataWidth != 64) begin : g_bad_width
      $error("ieee2fp_stream: DataWidth must be 16, 32 or 64");
   end

   typedef struct packed {
      logic [DataWidth+1:0] fp;
      logic [TagWidth-1:0]  tag;
   } item_t;

   logic [63:0] ieee_ext;
   conv_t       conv;
   item_t       in_item;
   logic        accept;

   // index 0 is the converter output, index NumStages the module output
   item_t item_d  [NumStages+1];
   logic  valid_d [NumStages+1];
   logic  ready_d [NumStages+1];

   always_comb begin
      ieee_ext                = '0;
      ieee_ext[DataWidth-1:0] = stream.ieee_i;
   end

   assign conv = ieee2fp_f(ieee_ext, DataWidth);

   if (DataWidth < 64) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^conv.fp[65:DataWidth+2];
   end

   always_comb begin
      in_item.fp  = conv.fp[DataWidth+1:0];
      in_item.tag = stream.tag_i;
   end

   assign item_d[0]          = in_item;
   assign valid_d[0]         = stream.valid_i;
   assign ready_d[NumStages] = stream.ready_i;

   for (genvar k = 0; k < NumStages; k++) begin : g_stage
      flopoco_pipe_reg #(
         .data_t (item_t)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .data_i  (item_d[k]),
         .valid_i (valid_d[k]),
         .ready_o (ready_d[k]),
         .data_o  (item_d[k+1]),
         .valid_o (valid_d[k+1]),
         .ready_i (ready_d[k+1])
      );
   end

   assign stream.ready_o = ready_d[0];
   assign stream.fp_o    = item_d[NumStages].fp;
   assign stream.tag_o   = item_d[NumStages].tag;
   assign stream.valid_o = valid_d[NumStages];

   assign accept = stream.valid_i && ready_d[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sub_cnt_o <= '0;
         nan_cnt_o <= '0;
      end else if (clr_i) begin
         sub_cnt_o <= '0;
         nan_cnt_o <= '0;
      end else begin
         if (accept && conv.sub && (sub_cnt_o != '1)) sub_cnt_o <= sub_cnt_o + 1'b1;
         if (accept && conv.nan && (nan_cnt_o != '1)) nan_cnt_o <= nan_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_ieee2fp_stream.sv
// Bench for ieee2fp_stream: four instances (32b/2 stages, 16b/0 stages,
// 64b/1 stage, 32b/3 stages with 3-bit tag and 2-bit counters) driven by
// directed and random operands, compared against a field-level reference.
module tb_ieee2fp_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic clr_a, clr_b, clr_c, clr_d;
   logic [15:0] sub_a, nan_a, sub_b, nan_b, sub_c, nan_c;
   logic [1:0]  sub_d, nan_d;

   ieee2fp_stream_if #(.DataWidth(32), .TagWidth(1)) if_a ();
   ieee2fp_stream_if #(.DataWidth(16), .TagWidth(1)) if_b ();
   ieee2fp_stream_if #(.DataWidth(64), .TagWidth(1)) if_c ();
   ieee2fp_stream_if #(.DataWidth(32), .TagWidth(3)) if_d ();

   ieee2fp_stream #(.DataWidth(32), .NumStages(2), .TagWidth(1), .CntWidth(16)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .stream(if_a), .clr_i(clr_a), .sub_cnt_o(sub_a), .nan_cnt_o(nan_a));
   ieee2fp_stream #(.DataWidth(16), .NumStages(0), .TagWidth(1), .CntWidth(16)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .stream(if_b), .clr_i(clr_b), .sub_cnt_o(sub_b), .nan_cnt_o(nan_b));
   ieee2fp_stream #(.DataWidth(64), .NumStages(1), .TagWidth(1), .CntWidth(16)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .stream(if_c), .clr_i(clr_c), .sub_cnt_o(sub_c), .nan_cnt_o(nan_c));
   ieee2fp_stream #(.DataWidth(32), .NumStages(3), .TagWidth(3), .CntWidth(2)) u_d (
      .clk_i(clk), .rst_ni(rst_n), .stream(if_d), .clr_i(clr_d), .sub_cnt_o(sub_d), .nan_cnt_o(nan_d));

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [65:0] fp;
      logic        nan;
      logic        sub;
   } ref_t;

   typedef struct {
      logic [65:0] fp;
      logic [2:0]  tag;
   } exp_t;

   exp_t        sb_d[$];
   int          got_d;
   logic        seen_full;
   logic        stall_prev;
   logic [33:0] prev_fp;
   logic [2:0]  prev_tag;
   int          exp_nan_d;
   int          exp_sub_d;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: classify by exponent/fraction values, assemble {exc,s,e,f}.
   function automatic ref_t model(input logic [63:0] x, input int dw);
      ref_t        r;
      int          e_w, f_w;
      logic [63:0] e, f, s, emax;
      logic [1:0]  exc;
      e_w  = (dw == 16) ? 5 : (dw == 64) ? 11 : 8;
      f_w  = dw - 1 - e_w;
      emax = (64'd1 << e_w) - 64'd1;
      f    = x & ((64'd1 << f_w) - 64'd1);
      e    = (x >> f_w) & emax;
      s    = (x >> (dw - 1)) & 64'd1;
      r.nan = (e == emax) && (f != 0);
      r.sub = (e == 0) && (f != 0);
      if (e == 0) begin
         exc = 2'b00;
         f   = 0;
      end else if (e == emax) begin
         exc = (f == 0) ? 2'b10 : 2'b11;
      end else begin
         exc = 2'b01;
      end
      r.fp = (66'(exc) << dw) | (66'(s) << (dw - 1)) | (66'(e) << f_w) | 66'(f);
      return r;
   endfunction

   function automatic logic [63:0] rand_op(input int dw);
      int          e_w, f_w;
      logic [63:0] e, f, s, emax;
      e_w  = (dw == 16) ? 5 : (dw == 64) ? 11 : 8;
      f_w  = dw - 1 - e_w;
      emax = (64'd1 << e_w) - 64'd1;
      f    = {$urandom, $urandom} & ((64'd1 << f_w) - 64'd1);
      e    = {32'd0, $urandom} & emax;
      s    = 64'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0: begin e = 0; f = 0; end
         1: begin e = 0; if (f == 0) f = 1; end
         2: begin e = emax; f = 0; end
         3: begin e = emax; if (f == 0) f = 1; end
         default: ;
      endcase
      return (s << (dw - 1)) | (e << f_w) | f;
   endfunction

   // One cycle of instance D: check against the scoreboard, then clock.
   task automatic cycle_d(output logic fired);
      logic exp_rdy, in_fire, out_fire;
      ref_t r;
      exp_t it;
      #1;
      exp_rdy = (sb_d.size() < 3) || if_d.ready_i;
      chk("d_ready", 66'(if_d.ready_o), 66'(exp_rdy));
      if (!exp_rdy) seen_full = 1'b1;
      if (sb_d.size() == 0) chk("d_idle", 66'(if_d.valid_o), 66'd0);
      if (if_d.valid_o && sb_d.size() != 0) begin
         chk("d_fp", 66'(if_d.fp_o), sb_d[0].fp);
         chk("d_tag", 66'(if_d.tag_o), 66'(sb_d[0].tag));
      end
      if (stall_prev) begin
         chk("d_hold_valid", 66'(if_d.valid_o), 66'd1);
         chk("d_hold_fp", 66'(if_d.fp_o), 66'(prev_fp));
         chk("d_hold_tag", 66'(if_d.tag_o), 66'(prev_tag));
      end
      chk("d_nan_cnt", 66'(nan_d), 66'(exp_nan_d));
      chk("d_sub_cnt", 66'(sub_d), 66'(exp_sub_d));
      r        = model(64'(if_d.ieee_i), 32);
      in_fire  = if_d.valid_i && exp_rdy;
      out_fire = if_d.valid_o && if_d.ready_i;
      stall_prev = if_d.valid_o && !if_d.ready_i;
      prev_fp    = if_d.fp_o;
      prev_tag   = if_d.tag_o;
      if (clr_d) begin
         exp_nan_d = 0;
         exp_sub_d = 0;
      end else if (in_fire) begin
         if (r.nan && exp_nan_d < 3) exp_nan_d++;
         if (r.sub && exp_sub_d < 3) exp_sub_d++;
      end
      if (out_fire && sb_d.size() != 0) begin
         void'(sb_d.pop_front());
         got_d++;
      end
      if (in_fire) begin
         it.fp  = r.fp;
         it.tag = if_d.tag_i;
         sb_d.push_back(it);
      end
      fired = in_fire;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] vec_a [4] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
   logic [33:0] exp_a [4] = '{34'h13F800000, 34'h080000000, 34'h27F800000, 34'h37FC00000};
   logic [31:0] sub_v [2] = '{32'h00000001, 32'h80400000};
   logic [33:0] sub_e [2] = '{34'h000000000, 34'h080000000};

   initial begin
      logic [63:0] t;
      logic [63:0] ops_c [10];
      logic [31:0] items [8];
      logic        fired;
      ref_t        r;
      int          idx, c;

      {if_a.ieee_i, if_a.tag_i, if_a.valid_i} = '0; if_a.ready_i = 1'b1;
      {if_b.ieee_i, if_b.tag_i, if_b.valid_i} = '0; if_b.ready_i = 1'b1;
      {if_c.ieee_i, if_c.tag_i, if_c.valid_i} = '0; if_c.ready_i = 1'b1;
      {if_d.ieee_i, if_d.tag_i, if_d.valid_i} = '0; if_d.ready_i = 1'b1;
      {clr_a, clr_b, clr_c, clr_d} = '0;
      got_d = 0; seen_full = 1'b0; stall_prev = 1'b0; prev_fp = '0; prev_tag = '0;
      exp_nan_d = 0; exp_sub_d = 0;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_valid", 66'(if_a.valid_o), 66'd0);
      chk("rst_a_fp", 66'(if_a.fp_o), 66'd0);
      chk("rst_a_tag", 66'(if_a.tag_o), 66'd0);
      chk("rst_a_ready", 66'(if_a.ready_o), 66'd1);
      chk("rst_a_cnt", 66'({sub_a, nan_a}), 66'd0);
      chk("rst_d_valid", 66'(if_d.valid_o), 66'd0);
      if_b.ready_i = 1'b0;
      #1;
      chk("rst_b_ready_lo", 66'(if_b.ready_o), 66'd0);
      if_b.ready_i = 1'b1;
      #1;
      chk("rst_b_ready_hi", 66'(if_b.ready_o), 66'd1);
      rst_n = 1'b1;
      tick();

      // 32-bit, 2 stages: back-to-back stream, latency 2
      for (int i = 0; i < 6; i++) begin
         if_a.valid_i = (i < 4);
         if_a.ieee_i  = (i < 4) ? vec_a[i] : 32'd0;
         #1;
         chk("a_valid", 66'(if_a.valid_o), 66'(i >= 2));
         chk("a_ready", 66'(if_a.ready_o), 66'd1);
         if (i >= 2) begin
            chk("a_fp", 66'(if_a.fp_o), 66'(exp_a[i-2]));
            r = model(64'(vec_a[i-2]), 32);
            chk("a_fp_model", 66'(if_a.fp_o), r.fp);
         end
         tick();
      end
      chk("a_nan_cnt", 66'(nan_a), 66'd1);
      chk("a_sub_cnt0", 66'(sub_a), 66'd0);

      // subnormals flush to signed zero
      for (int i = 0; i < 4; i++) begin
         if_a.valid_i = (i < 2);
         if_a.ieee_i  = (i < 2) ? sub_v[i] : 32'd0;
         #1;
         chk("a_sub_valid", 66'(if_a.valid_o), 66'(i >= 2));
         if (i >= 2) chk("a_sub_fp", 66'(if_a.fp_o), 66'(sub_e[i-2]));
         tick();
      end
      chk("a_sub_cnt", 66'(sub_a), 66'd2);

      // 16-bit, combinational
      if_b.valid_i = 1'b1;
      if_b.ieee_i  = 16'h3C00;
      #1;
      chk("b_fp_one", 66'(if_b.fp_o), 66'h13C00);
      chk("b_valid", 66'(if_b.valid_o), 66'd1);
      for (int i = 0; i < 20; i++) begin
         t = rand_op(16);
         if_b.ieee_i = t[15:0];
         #1;
         r = model(t, 16);
         chk("b_fp_rand", 66'(if_b.fp_o), r.fp);
      end
      if_b.valid_i = 1'b0;
      tick();

      // 64-bit, 1 stage
      ops_c[0] = 64'h3FF0000000000000;
      for (int i = 1; i < 10; i++) ops_c[i] = rand_op(64);
      for (int i = 0; i < 11; i++) begin
         if_c.valid_i = (i < 10);
         if_c.ieee_i  = (i < 10) ? ops_c[i] : 64'd0;
         #1;
         chk("c_valid", 66'(if_c.valid_o), 66'(i >= 1));
         if (i == 1) chk("c_fp_one", 66'(if_c.fp_o), 66'h1_3FF0000000000000);
         if (i >= 1) begin
            r = model(ops_c[i-1], 64);
            chk("c_fp_rand", 66'(if_c.fp_o), r.fp);
         end
         tick();
      end

      // 3 stages, 8 tagged items, output stalled for cycles 2..6
      for (int i = 0; i < 8; i++) begin
         t = rand_op(32);
         items[i] = t[31:0];
      end
      idx = 0; c = 0; got_d = 0; seen_full = 1'b0;
      while (got_d < 8 && c < 200) begin
         if_d.valid_i = (idx < 8);
         if_d.ieee_i  = (idx < 8) ? items[idx] : 32'd0;
         if_d.tag_i   = 3'(idx);
         if_d.ready_i = !(c >= 2 && c <= 6);
         cycle_d(fired);
         if (fired) idx++;
         c++;
      end
      chk("d_items_out", 66'(got_d), 66'd8);
      chk("d_full_seen", 66'(seen_full), 66'd1);
      chk("d_sb_empty", 66'(sb_d.size()), 66'd0);

      // random traffic with random backpressure, then drain
      for (int i = 0; i < 80; i++) begin
         t = rand_op(32);
         if_d.valid_i = 1'($urandom_range(0, 1));
         if_d.ieee_i  = t[31:0];
         if_d.tag_i   = 3'($urandom_range(0, 7));
         if_d.ready_i = ($urandom_range(0, 3) != 0);
         cycle_d(fired);
      end
      if_d.valid_i = 1'b0;
      if_d.ready_i = 1'b1;
      c = 0;
      while (sb_d.size() != 0 && c < 50) begin
         cycle_d(fired);
         c++;
      end
      chk("d_drained", 66'(sb_d.size()), 66'd0);

      // counter saturation at 3 and clear priority
      clr_d = 1'b1;
      cycle_d(fired);
      clr_d = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if_d.valid_i = 1'b1;
         if_d.ieee_i  = 32'h7FC00000 | 32'(i);
         if_d.tag_i   = 3'(i);
         cycle_d(fired);
      end
      if_d.valid_i = 1'b0;
      cycle_d(fired);
      chk("d_nan_sat", 66'(nan_d), 66'd3);
      if_d.valid_i = 1'b1;
      if_d.ieee_i  = 32'hFFC00000;
      clr_d = 1'b1;
      cycle_d(fired);
      if_d.valid_i = 1'b0;
      clr_d = 1'b0;
      cycle_d(fired);
      chk("d_nan_clr", 66'(nan_d), 66'd0);
      c = 0;
      while (sb_d.size() != 0 && c < 50) begin
         cycle_d(fired);
         c++;
      end

      // asynchronous reset with two items held in instance A
      if_a.ready_i = 1'b0;
      if_a.valid_i = 1'b1;
      if_a.ieee_i  = 32'h7FC00000;
      tick();
      if_a.ieee_i  = 32'h7F800001;
      tick();
      if_a.valid_i = 1'b0;
      #1;
      chk("a_held_valid", 66'(if_a.valid_o), 66'd1);
      chk("a_held_nan", 66'(nan_a), 66'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("a_arst_valid", 66'(if_a.valid_o), 66'd0);
      chk("a_arst_fp", 66'(if_a.fp_o), 66'd0);
      chk("a_arst_cnt", 66'({sub_a, nan_a}), 66'd0);
      chk("d_arst_cnt", 66'({sub_d, nan_d}), 66'd0);
      sb_d.delete();
      exp_nan_d = 0; exp_sub_d = 0; stall_prev = 1'b0;
      tick();
      rst_n = 1'b1;
      if_a.ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("a_no_stale", 66'(if_a.valid_o), 66'd0);
         tick();
      end
      chk("a_post_cnt", 66'(nan_a), 66'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "bench did not complete");
   end

endmodule
